// File: rtl/step_seq_pkg.sv
// step_seq_pkg: shared constants for the step sequencer.
//   State encoding (also the value driven on mode), default widths, pulse counter width.
package step_seq_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STEP  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;
  localparam int DIV_W_DEF   = 8;
  localparam int BURST_W_DEF = 4;
  localparam int CNT_W       = 16;
endpackage

// File: rtl/step_sequencer_if.sv
// step_sequencer_if: request/enable bundle between the push-button front end and the sequencer.
//   master: drives stepReq, burstReq, runSw, burstLen, divisor; observes clkEn, busy, mode.
//   slave : the sequencer side.
//   stepCount exists only when STEP_SEQ_CNT_EN is defined.
interface step_sequencer_if import step_seq_pkg::*; #(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) ();
  logic               stepReq;
  logic               burstReq;
  logic               runSw;
  logic [BURST_W-1:0] burstLen;
  logic [DIV_W-1:0]   divisor;
  logic               clkEn;
  logic               busy;
  logic [1:0]         mode;
`ifdef STEP_SEQ_CNT_EN
  logic [CNT_W-1:0]   stepCount;
`endif
  modport master (
    output stepReq, burstReq, runSw, burstLen, divisor,
    input  clkEn, busy, mode
`ifdef STEP_SEQ_CNT_EN
    , input stepCount
`endif
  );
  modport slave (
    input  stepReq, burstReq, runSw, burstLen, divisor,
    output clkEn, busy, mode
`ifdef STEP_SEQ_CNT_EN
    , output stepCount
`endif
  );
endinterface

// File: rtl/tick_divider.sv
// tick_divider: divide counter 0..div with captured divisor, shared by BURST and RUN.
//   clk, reset (async active-low)
//   load_i  : capture div_i and clear count
//   clr_i   : clear count
//   adv_i   : advance count, wrapping to 0 after terminal count
//   div_i   : divisor to capture
//   tc_o    : count equals captured divisor this cycle
//   tc_nxt_o: count will equal divisor next cycle (lets the caller register clkEn)
module tick_divider #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         clr_i,
  input  logic         adv_i,
  input  logic [W-1:0] div_i,
  output logic         tc_o,
  output logic         tc_nxt_o
);
  logic [W-1:0] cnt_q, cnt_d, div_q, div_d;
  assign tc_o     = cnt_q == div_q;
  assign tc_nxt_o = cnt_d == div_d;
  always_comb begin
    div_d = load_i ? div_i : div_q;
    cnt_d = (load_i || clr_i) ? '0 : adv_i ? (tc_o ? '0 : cnt_q + W'(1)) : cnt_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
endmodule

// File: rtl/step_sequencer.sv
// step_sequencer: clock-enable controller issuing single, burst or free-run clkEn pulses.
//   clk, reset (async active-low)
//   bus.slave: stepReq/burstReq pulses, runSw level, burstLen, divisor in;
//              clkEn (registered), busy, mode, and stepCount when STEP_SEQ_CNT_EN is defined.
module step_sequencer import step_seq_pkg::*; #(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input logic             clk,
  input logic             reset,
  step_sequencer_if.slave bus
);
  logic [1:0]         state_q, state_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               clk_en_q, clk_en_d;
  logic               load, clr, adv, tc, tc_nxt;
  tick_divider #(.W(DIV_W)) u_div (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .clr_i   (clr),
    .adv_i   (adv),
    .div_i   (bus.divisor),
    .tc_o    (tc),
    .tc_nxt_o(tc_nxt)
  );
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    load    = 1'b0;
    clr     = 1'b0;
    adv     = 1'b0;
    case (state_q)
      S_IDLE:
        if (bus.runSw) begin
          state_d = S_RUN;
          load    = 1'b1;
        end else if (bus.burstReq) begin
          state_d = S_BURST;
          load    = 1'b1;
          rem_d   = bus.burstLen;
        end else if (bus.stepReq) state_d = S_STEP;
      S_STEP: state_d = S_IDLE;
      S_BURST: begin
        // rem_q==0 covers a zero-length burst: one busy cycle, no pulse
        if (rem_q == '0 || (tc && rem_q == BURST_W'(1))) begin
          state_d = S_IDLE;
          clr     = 1'b1;
        end else adv = 1'b1;
        rem_d = (tc && rem_q != '0) ? rem_q - BURST_W'(1) : rem_q;
      end
      default:
        if (!bus.runSw) begin
          state_d = S_IDLE;
          clr     = 1'b1;
        end else adv = 1'b1;
    endcase
    // clkEn is registered, so it is decided from next-cycle state and count
    clk_en_d = (state_d == S_STEP) ||
               (state_d == S_BURST && rem_d != '0 && tc_nxt) ||
               (state_d == S_RUN && tc_nxt);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      clk_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      clk_en_q <= clk_en_d;
    end
  assign bus.clkEn = clk_en_q;
  assign bus.busy  = state_q != S_IDLE;
  assign bus.mode  = state_q;
`ifdef STEP_SEQ_CNT_EN
  logic [CNT_W-1:0] pulses_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) pulses_q <= '0;
    else if (clk_en_q) pulses_q <= pulses_q + CNT_W'(1);
  assign bus.stepCount = pulses_q;
`endif
endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: directed vector table plus hand-written reset sequence for step_sequencer.
module tb_step_sequencer;
  import step_seq_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  step_sequencer_if #(.DIV_W(8), .BURST_W(4)) sif ();
  step_sequencer #(.DIV_W(8), .BURST_W(4)) dut (.clk(clk), .reset(reset), .bus(sif));
  int errs = 0;
  int checks = 0;
  typedef struct packed {
    logic       st;
    logic       bu;
    logic       ru;
    logic [3:0] len;
    logic [7:0] dv;
    logic       ce;
    logic [1:0] md;
  } vec_t;
  vec_t vq[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic add(input logic st, bu, ru, input logic [3:0] len, input logic [7:0] dv,
                     input logic ce, input logic [1:0] md);
    vq.push_back('{st, bu, ru, len, dv, ce, md});
  endtask
  task automatic chk_out(input string tag, input logic ce, input logic [1:0] md);
    chk({tag, " clkEn"}, 32'(sif.clkEn), 32'(ce));
    chk({tag, " mode"}, 32'(sif.mode), 32'(md));
    chk({tag, " busy"}, 32'(sif.busy), 32'(md != S_IDLE));
  endtask
  initial begin
    int exp_cnt;
    int pulses;
    int busy_seen;
    sif.stepReq = 0; sif.burstReq = 0; sif.runSw = 0; sif.burstLen = 0; sif.divisor = 0;
    #1;
    chk_out("reset", 1'b0, S_IDLE);
`ifdef STEP_SEQ_CNT_EN
    chk("reset stepCount", 32'(sif.stepCount), 0);
`endif
    tick();
    reset = 1'b1;
    tick();
    chk_out("post-reset", 1'b0, S_IDLE);
    // step, ignored re-step
    add(1,0,0,3,2, 1,S_STEP);
    add(1,0,0,3,2, 0,S_IDLE);
    add(0,0,0,3,2, 0,S_IDLE);
    // burst len 3 div 2; divisor change and step while busy ignored
    add(0,1,0,3,2, 0,S_BURST);
    add(0,0,0,3,2, 0,S_BURST);
    add(0,0,0,3,2, 1,S_BURST);
    add(1,0,0,3,0, 0,S_BURST);
    add(0,0,0,3,0, 0,S_BURST);
    add(0,0,0,3,0, 1,S_BURST);
    add(0,0,0,3,0, 0,S_BURST);
    add(0,0,0,3,0, 0,S_BURST);
    add(0,0,0,3,0, 1,S_BURST);
    add(0,0,0,3,2, 0,S_IDLE);
    // run beats burst; runSw drops off terminal count
    add(0,1,1,3,1, 0,S_RUN);
    add(0,0,1,3,1, 1,S_RUN);
    add(0,0,1,3,1, 0,S_RUN);
    add(0,0,0,3,1, 0,S_IDLE);
    // runSw drops in the terminal-count cycle
    add(0,0,1,3,1, 0,S_RUN);
    add(0,0,1,3,1, 1,S_RUN);
    add(0,0,0,3,1, 0,S_IDLE);
    // divisor 0 run for 5 cycles
    for (int i = 0; i < 5; i++) add(0,0,1,3,0, 1,S_RUN);
    add(0,0,0,3,0, 0,S_IDLE);
    // zero-length burst
    add(0,1,0,0,0, 0,S_BURST);
    add(0,0,0,0,0, 0,S_IDLE);
    // runSw rising during a burst waits for IDLE
    add(0,1,0,1,1, 0,S_BURST);
    add(0,0,1,1,1, 1,S_BURST);
    add(0,0,1,1,1, 0,S_IDLE);
    add(0,0,1,1,1, 0,S_RUN);
    add(0,0,0,1,1, 0,S_IDLE);
    exp_cnt = 0;
    for (int i = 0; i < vq.size(); i++) begin
      sif.stepReq = vq[i].st; sif.burstReq = vq[i].bu; sif.runSw = vq[i].ru;
      sif.burstLen = vq[i].len; sif.divisor = vq[i].dv;
      tick();
      chk_out($sformatf("v%0d", i + 1), vq[i].ce, vq[i].md);
`ifdef STEP_SEQ_CNT_EN
      chk($sformatf("v%0d stepCount", i + 1), 32'(sif.stepCount), 32'(exp_cnt[15:0]));
`endif
      exp_cnt += int'(vq[i].ce);
    end
    sif.stepReq = 0; sif.burstReq = 0; sif.runSw = 0;
    tick();
    // reset mid-run with divisor 3: pulse in 4th RUN cycle, then asynchronous abort
    sif.divisor = 8'd3;
    sif.runSw = 1;
    tick();
    chk_out("rst run0", 1'b0, S_RUN);
    tick();
    tick();
    tick();
    chk_out("rst run3", 1'b1, S_RUN);
    #2 reset = 1'b0;
    #1;
    chk_out("rst async", 1'b0, S_IDLE);
`ifdef STEP_SEQ_CNT_EN
    chk("rst stepCount", 32'(sif.stepCount), 0);
`endif
    sif.runSw = 0;
    tick();
    tick();
    reset = 1'b1;
    pulses = 0;
    busy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      pulses += int'(sif.clkEn);
      busy_seen += int'(sif.busy);
    end
    chk("rst no pulse", 32'(pulses), 0);
    chk("rst no busy", 32'(busy_seen), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
